fifo_burst_drain: RTL and testbench
===================================

// Module: fifo_burst_drain
// PURPOSE
//  Reader end of a StreamingFIFO: monitors the FIFO occupancy count and drains its AXI-Stream output
//  in fixed-length bursts, tagging the final beat with TLAST. Sits between a StreamingFIFO and a
//  burst-oriented consumer (DMA/packetiser) that must never see a partial burst except on flush.
// PARAMETERS
//  WIDTH      24   data width (TDATA bits) on both streams
//  BURST_LEN  16   beats per normal burst; legal range 2..FIFO_DEPTH
//  CNT_W      10   width of in_count; must hold FIFO_DEPTH
//  FIFO_DEPTH 512  depth of upstream FIFO; checked by elaboration assert against BURST_LEN
// PORTS
//  ap_clk          in   1        clock; all logic rising-edge
//  ap_rst_n        in   1        asynchronous active-low reset
//  in_count        in   CNT_W    upstream FIFO occupancy; updates 1 cycle after each pop
//  flush           in   1        level; permit a partial burst of the remaining words
//  in0_V_V_TDATA   in   WIDTH    upstream data
//  in0_V_V_TVALID  in   1        upstream valid
//  in0_V_V_TREADY  out  1        pop strobe to FIFO
//  out_V_V_TDATA   out  WIDTH    registered output data
//  out_V_V_TVALID  out  1        output valid
//  out_V_V_TREADY  in   1        downstream ready
//  out_V_V_TLAST   out  1        high on the last beat of each burst
//  busy            out  1        high while state != IDLE or the output register is full
// BEHAVIOUR
//  Reset: state=IDLE, beat_cnt=0, len=0, out TVALID/TLAST=0, TDATA=0, in0 TREADY=0, busy=0.
//  FSM IDLE -> ARM -> BURST -> IDLE.
//   IDLE: the transition to ARM is taken when in_count>=BURST_LEN, or when flush=1 and in_count!=0.
//         Latch len=min(in_count,BURST_LEN). If both conditions hold, a full burst takes precedence.
//   ARM:  one cycle; no pop. BURST: pop until beat_cnt==len-1 is accepted, then go to IDLE.
//   After BURST, IDLE waits 1 cycle (guard) before evaluating in_count, because count lags the pops.
//  Output register (1 entry): in0 TREADY = (state==BURST) && (!out TVALID || out TREADY).
//   On an input handshake, the register loads TDATA. TLAST is set when beat_cnt==len-1.
//   out TVALID holds, with TDATA/TLAST stable, until out TREADY; no combinational in->out path.
//  Latency: input accept -> output valid = 1 cycle. Full throughput is 1 beat/cycle with TREADY high.
//  In BURST, the block stalls with no pop while in0 TVALID=0; beat_cnt holds.
//  The FSM does not abort a burst; flush changes only the IDLE decision.
//  Downstream backpressure on the TLAST beat: the FSM may return to IDLE. No pop of the next burst
//   can complete before the register drains, which the TREADY rule guarantees.
//  beat_cnt is $clog2(BURST_LEN+1) bits; it is cleared entering ARM and never wraps within a burst.
//  Async reset mid-burst: all state clears immediately. The consumed upstream words are lost, by design.
// CONFIGURATION
//  FIFO_BURST_DRAIN_STATS_EN defined: adds outputs burst_cnt[31:0] (bursts completed, wrapping),
//   partial_cnt[15:0] (flush-shortened bursts, saturating) and stall_cnt[31:0] (cycles with
//   out TVALID && !out TREADY, saturating). All three are cleared by reset.
//  Undefined: these ports and counters are absent; the rest of the behaviour is identical.
// STRUCTURE
//  Shared package fifo_burst_drain_pkg: enum state_t {IDLE,ARM,BURST}, localparam BEAT_W function,
//   and the stats counter widths.
//  One sub-module, axis_out_reg: the single-entry output register with TDATA/TLAST/TVALID and the
//   ready logic. The FSM and counters stay in the top module.
// TESTING (bench models a Q_srl-like FIFO with 1-cycle-lagged count)
//  Preload 16 words, out TREADY=1 -> 16 beats, TLAST on beat 16; first out TVALID 3 cycles after count>=16.
//  Preload 40 words, no flush -> exactly 2 bursts (32 beats). 8 words remain; busy=0 afterwards.
//  Then assert flush -> 1 burst of 8 beats, TLAST on beat 8; partial_cnt=1 with STATS_EN.
//  Random out TREADY 50% over 4 bursts -> data order preserved, TDATA/TLAST stable while stalled,
//   and stall_cnt equals the stalled cycles.
//  in0 TVALID dropped for 5 cycles mid-burst -> no pop, beat_cnt holds, and the burst completes with 16 beats.
//  ap_rst_n pulsed low at beat 7 -> all outputs 0 the same cycle. After release, the FSM is in IDLE
//   and re-arms on the next count>=16.

Source files
------------

// File: rtl/fifo_burst_drain_pkg.sv
// Shared types and widths for the burst-drain reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum, beat counter width helper, stats counter widths.
package fifo_burst_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    BURST = 2'd2
  } state_t;

  // Beat counter must represent 0..burst_len without wrapping inside a burst.
  function automatic int beat_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

  localparam int BURST_CNT_W   = 32;
  localparam int PARTIAL_CNT_W = 16;
  localparam int STALL_CNT_W   = 32;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register with TLAST side-band.
// Latency: 1 cycle from input handshake to output valid.
// Backpressure: accepts a new beat only when enabled and empty or draining this cycle.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en                upstream may be accepted (owner FSM is bursting)
//   s_vld/s_rdy/s_dat/s_last   upstream beat
//   m_vld/m_rdy/m_dat/m_last   registered downstream beat
module axis_out_reg #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             s_vld,
  input  logic [WIDTH-1:0] s_dat,
  input  logic             s_last,
  output logic             s_rdy,
  output logic             m_vld,
  output logic [WIDTH-1:0] m_dat,
  output logic             m_last,
  input  logic             m_rdy
);

  // Ready depends only on registered state and downstream ready, so there is
  // never a combinational path from upstream data/valid to the outputs.
  assign s_rdy = en && (!m_vld || m_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld  <= 1'b0;
      m_dat  <= '0;
      m_last <= 1'b0;
    end else if (s_vld && s_rdy) begin
      m_vld  <= 1'b1;
      m_dat  <= s_dat;
      m_last <= s_last;
    end else if (m_rdy) begin
      // Drained with nothing new: drop TLAST too so it never lingers.
      m_vld  <= 1'b0;
      m_last <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_drain.sv
// Drains an upstream FIFO in fixed-length bursts, TLAST on the final beat; partial burst only on flush.
// Latency: count threshold -> first output valid 3 cycles; input accept -> output valid 1 cycle.
// Backpressure: pops stall while the output register is full and downstream not ready, or input invalid.
//
// Optional feature macro: FIFO_BURST_DRAIN_STATS_EN adds burst_cnt, partial_cnt, stall_cnt outputs.
// Ports:
//   ap_clk, ap_rst_n       clock, async active-low reset
//   in_count               upstream occupancy (lags pops by a cycle)
//   flush                  allow a short burst of whatever remains
//   in0_V_V_*              upstream AXI-Stream (TREADY is the FIFO pop strobe)
//   out_V_V_*              downstream AXI-Stream with TLAST
//   busy                   FSM active or output register occupied
module fifo_burst_drain
  import fifo_burst_drain_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int BURST_LEN  = 16,
  parameter int CNT_W      = 10,
  parameter int FIFO_DEPTH = 512
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [CNT_W-1:0] in_count,
  input  logic             flush,
  input  logic [WIDTH-1:0] in0_V_V_TDATA,
  input  logic             in0_V_V_TVALID,
  output logic             in0_V_V_TREADY,
  output logic [WIDTH-1:0] out_V_V_TDATA,
  output logic             out_V_V_TVALID,
  input  logic             out_V_V_TREADY,
  output logic             out_V_V_TLAST,
`ifdef FIFO_BURST_DRAIN_STATS_EN
  output logic [BURST_CNT_W-1:0]   burst_cnt,
  output logic [PARTIAL_CNT_W-1:0] partial_cnt,
  output logic [STALL_CNT_W-1:0]   stall_cnt,
`endif
  output logic             busy
);

  localparam int BEAT_W = beat_w(BURST_LEN);

  if (BURST_LEN < 2 || BURST_LEN > FIFO_DEPTH) begin : g_bad_burst_len
    $error("fifo_burst_drain: BURST_LEN must be within 2..FIFO_DEPTH");
  end
  if (FIFO_DEPTH >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("fifo_burst_drain: CNT_W too narrow to hold FIFO_DEPTH");
  end

  state_t            state, state_nxt;
  logic              guard;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] len;
  logic              full_avail;
  logic              flush_avail;
  logic              pop;
  logic              last_beat;
  logic              burst_done;

  assign full_avail  = (in_count >= CNT_W'(BURST_LEN));
  assign flush_avail = flush && (in_count != '0);
  assign pop         = in0_V_V_TREADY && in0_V_V_TVALID;
  assign last_beat   = (beat_cnt == len - BEAT_W'(1));
  assign burst_done  = pop && last_beat;

  always_comb begin
    state_nxt = state;
    case (state)
      // guard skips one evaluation after a burst: in_count has not yet
      // caught up with the final pops.
      IDLE:    if (!guard && (full_avail || flush_avail)) state_nxt = ARM;
      ARM:     state_nxt = BURST;
      BURST:   if (burst_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= IDLE;
      guard    <= 1'b0;
      beat_cnt <= '0;
      len      <= '0;
    end else begin
      state <= state_nxt;
      guard <= (state == BURST) && (state_nxt == IDLE);
      if (state == IDLE && state_nxt == ARM) begin
        beat_cnt <= '0;
        // A full burst wins whenever enough words are present, flush or not.
        len      <= full_avail ? BEAT_W'(BURST_LEN) : BEAT_W'(in_count);
      end else if (pop && !last_beat) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  axis_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .en     (state == BURST),
    .s_vld  (in0_V_V_TVALID),
    .s_dat  (in0_V_V_TDATA),
    .s_last (last_beat),
    .s_rdy  (in0_V_V_TREADY),
    .m_vld  (out_V_V_TVALID),
    .m_dat  (out_V_V_TDATA),
    .m_last (out_V_V_TLAST),
    .m_rdy  (out_V_V_TREADY)
  );

  assign busy = (state != IDLE) || out_V_V_TVALID;

`ifdef FIFO_BURST_DRAIN_STATS_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      burst_cnt   <= '0;
      partial_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (burst_done) begin
        burst_cnt <= burst_cnt + BURST_CNT_W'(1);
        if (len != BEAT_W'(BURST_LEN) && partial_cnt != '1)
          partial_cnt <= partial_cnt + PARTIAL_CNT_W'(1);
      end
      if (out_V_V_TVALID && !out_V_V_TREADY && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain with a lagged-count FIFO model and output scoreboard.
// Latency: n/a.
// Backpressure: downstream ready driven level or random per test phase.
module tb_fifo_burst_drain;
  localparam int WIDTH = 24;
  localparam int CNT_W = 10;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic [CNT_W-1:0] in_count;
  logic             flush;
  logic [WIDTH-1:0] in0_V_V_TDATA;
  logic             in0_V_V_TVALID;
  logic             in0_V_V_TREADY;
  logic [WIDTH-1:0] out_V_V_TDATA;
  logic             out_V_V_TVALID;
  logic             out_V_V_TREADY;
  logic             out_V_V_TLAST;
  logic             busy;
`ifdef FIFO_BURST_DRAIN_STATS_EN
  logic [31:0] burst_cnt;
  logic [15:0] partial_cnt;
  logic [31:0] stall_cnt;
`endif

  fifo_burst_drain #(.WIDTH(WIDTH), .BURST_LEN(16), .CNT_W(CNT_W), .FIFO_DEPTH(512)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_count(in_count), .flush(flush),
    .in0_V_V_TDATA(in0_V_V_TDATA), .in0_V_V_TVALID(in0_V_V_TVALID), .in0_V_V_TREADY(in0_V_V_TREADY),
    .out_V_V_TDATA(out_V_V_TDATA), .out_V_V_TVALID(out_V_V_TVALID), .out_V_V_TREADY(out_V_V_TREADY),
    .out_V_V_TLAST(out_V_V_TLAST),
`ifdef FIFO_BURST_DRAIN_STATS_EN
    .burst_cnt(burst_cnt), .partial_cnt(partial_cnt), .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic             last;
  } beat_t;

  logic [WIDTH-1:0] fifo_q[$];
  beat_t            sb[$];
  int               checks = 0;
  int               errors = 0;
  int               exp_len = 16;
  int               exp_beat = 0;
  int               beats_out = 0;
  int               lasts_out = 0;
  int               pops_total = 0;
  int               stalls_seen = 0;
  int               prev_size = 0;
  int               cyc = 0;
  int               cnt_cyc = -1;
  int               vld_cyc = -1;
  bit               rdy_random = 0;
  bit               drop_vld = 0;
  bit               held = 0;
  logic [WIDTH-1:0] held_dat;
  logic             held_last;
  logic [WIDTH-1:0] next_word = 24'h100;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    in0_V_V_TVALID = (fifo_q.size() > 0) && !drop_vld;
    in0_V_V_TDATA  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    out_V_V_TREADY = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_word);
      next_word = next_word + 24'h1;
    end
    drive();
  endtask

  // One clock: sample mid-cycle, update the models, then drive after the edge.
  task automatic tick();
    bit    pop, acc;
    beat_t e;
    @(negedge ap_clk);
    cyc++;
    pop = in0_V_V_TREADY && in0_V_V_TVALID;
    acc = out_V_V_TVALID && out_V_V_TREADY;
    if (cnt_cyc < 0 && in_count >= 16) cnt_cyc = cyc;
    if (cnt_cyc >= 0 && vld_cyc < 0 && out_V_V_TVALID) vld_cyc = cyc;
    if (held) begin
      chk("hold_vld", 32'(out_V_V_TVALID), 32'd1);
      chk("hold_dat", 32'(out_V_V_TDATA), 32'(held_dat));
      chk("hold_last", 32'(out_V_V_TLAST), 32'(held_last));
    end
    held = out_V_V_TVALID && !out_V_V_TREADY;
    if (held) begin
      held_dat  = out_V_V_TDATA;
      held_last = out_V_V_TLAST;
      stalls_seen++;
    end
    if (acc) begin
      beats_out++;
      if (out_V_V_TLAST) lasts_out++;
      if (sb.size() == 0) chk("sb_unexpected_beat", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("out_dat", 32'(out_V_V_TDATA), 32'(e.dat));
        chk("out_last", 32'(out_V_V_TLAST), 32'(e.last));
      end
    end
    if (pop) begin
      e.dat  = fifo_q[0];
      e.last = (exp_beat == exp_len - 1);
      sb.push_back(e);
      exp_beat = (exp_beat == exp_len - 1) ? 0 : exp_beat + 1;
      void'(fifo_q.pop_front());
      pops_total++;
    end
    @(posedge ap_clk);
    #1;
    in_count  = CNT_W'(prev_size);
    prev_size = fifo_q.size();
    drive();
  endtask

  task automatic run_beats(input int n, input int limit);
    int start = beats_out;
    int k = 0;
    while (beats_out - start < n && k < limit) begin
      tick();
      k++;
    end
    if (beats_out - start < n) chk("timeout_beats", 32'(beats_out - start), 32'(n));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int b0, l0, p0;

  initial begin
    ap_rst_n = 1'b0;
    in_count = '0;
    flush    = 1'b0;
    drive();
    #12;
    chk("rst_tvalid", 32'(out_V_V_TVALID), 32'd0);
    chk("rst_tlast", 32'(out_V_V_TLAST), 32'd0);
    chk("rst_tdata", 32'(out_V_V_TDATA), 32'd0);
    chk("rst_tready", 32'(in0_V_V_TREADY), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    idle(2);
    ap_rst_n = 1'b1;
    idle(2);

    // Single full burst with latency check.
    b0 = beats_out; l0 = lasts_out;
    cnt_cyc = -1; vld_cyc = -1;
    preload(16);
    run_beats(16, 200);
    idle(5);
    chk("t1_beats", 32'(beats_out - b0), 32'd16);
    chk("t1_lasts", 32'(lasts_out - l0), 32'd1);
    chk("t1_latency", 32'(vld_cyc - cnt_cyc), 32'd3);

    // 40 words without flush: two bursts, 8 words left behind.
    b0 = beats_out; l0 = lasts_out;
    preload(40);
    run_beats(32, 400);
    idle(12);
    chk("t2_beats", 32'(beats_out - b0), 32'd32);
    chk("t2_lasts", 32'(lasts_out - l0), 32'd2);
    chk("t2_left", 32'(fifo_q.size()), 32'd8);
    chk("t2_busy", 32'(busy), 32'd0);

    // Flush drains the remaining 8 as one short burst.
    b0 = beats_out; l0 = lasts_out;
    exp_len = 8;
    flush = 1'b1;
    run_beats(8, 200);
    idle(10);
    flush = 1'b0;
    exp_len = 16;
    chk("t3_beats", 32'(beats_out - b0), 32'd8);
    chk("t3_lasts", 32'(lasts_out - l0), 32'd1);
    chk("t3_left", 32'(fifo_q.size()), 32'd0);
`ifdef FIFO_BURST_DRAIN_STATS_EN
    chk("t3_partial_cnt", 32'(partial_cnt), 32'd1);
    chk("t3_burst_cnt", burst_cnt, 32'd4);
`endif

    // Random downstream backpressure over four bursts.
    b0 = beats_out; l0 = lasts_out;
    rdy_random = 1;
    preload(64);
    run_beats(64, 2000);
    rdy_random = 0;
    idle(10);
    chk("t4_beats", 32'(beats_out - b0), 32'd64);
    chk("t4_lasts", 32'(lasts_out - l0), 32'd4);
`ifdef FIFO_BURST_DRAIN_STATS_EN
    chk("t4_stall_cnt", stall_cnt, 32'(stalls_seen));
    chk("t4_burst_cnt", burst_cnt, 32'd8);
`endif

    // Upstream valid dropped mid-burst for 5 cycles.
    b0 = beats_out; l0 = lasts_out;
    preload(16);
    run_beats(4, 200);
    drop_vld = 1;
    drive();
    p0 = pops_total;
    idle(5);
    chk("t5_no_pop", 32'(pops_total - p0), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    drop_vld = 0;
    drive();
    run_beats(16 - (beats_out - b0), 200);
    idle(10);
    chk("t5_beats", 32'(beats_out - b0), 32'd16);
    chk("t5_lasts", 32'(lasts_out - l0), 32'd1);

    // Reset pulse at beat 7.
    b0 = beats_out;
    preload(16);
    run_beats(7, 200);
    ap_rst_n = 1'b0;
    #1;
    chk("r_tvalid", 32'(out_V_V_TVALID), 32'd0);
    chk("r_tlast", 32'(out_V_V_TLAST), 32'd0);
    chk("r_tdata", 32'(out_V_V_TDATA), 32'd0);
    chk("r_tready", 32'(in0_V_V_TREADY), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
`ifdef FIFO_BURST_DRAIN_STATS_EN
    chk("r_burst_cnt", burst_cnt, 32'd0);
    chk("r_stall_cnt", stall_cnt, 32'd0);
`endif
    sb.delete();
    held = 0;
    exp_beat = 0;
    tick();
    ap_rst_n = 1'b1;
    b0 = beats_out;
    idle(10);
    chk("r_idle_beats", 32'(beats_out - b0), 32'd0);
    chk("r_idle_busy", 32'(busy), 32'd0);
    b0 = beats_out; l0 = lasts_out;
    cnt_cyc = -1; vld_cyc = -1;
    preload(16);
    run_beats(16, 200);
    idle(10);
    chk("r_beats", 32'(beats_out - b0), 32'd16);
    chk("r_lasts", 32'(lasts_out - l0), 32'd1);
    chk("r_latency", 32'(vld_cyc - cnt_cyc), 32'd3);
    chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef FIFO_BURST_DRAIN_STATS_EN
    chk("r_burst_cnt_after", burst_cnt, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
